axi_lite_mem_arbiter: RTL and testbench
=======================================

Name: axi_lite_mem_arbiter

Overview:
- Shares one AXI4-Lite master port between two requesters inside the RV32IM core:
  - instruction fetch (port I, read-only);
  - load/store memory stage (port D, read/write).
- Sits between the fetch/mem stages and the SoC interconnect.
- Sequences one outstanding AXI4-Lite transaction at a time.
- Arbitrates by round-robin on contention.
- Returns read data, completion and error to the granted requester.

Parameters:
ADDR_WIDTH, 32, width of requester and AXI addresses
DATA_WIDTH, 32, width of data buses; strobe width is DATA_WIDTH/8

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous active-high reset
i_req  in  1  fetch read request; held with i_addr stable until i_done
i_addr  in  ADDR_WIDTH  fetch address
i_rdata  out  DATA_WIDTH  fetch read data, valid when i_done
i_done  out  1  one-cycle completion pulse for port I
i_err  out  1  asserted with i_done if rresp != OKAY
d_req  in  1  data request; held with d_we/d_addr/d_wdata/d_wstrb stable until d_done
d_we  in  1  1 = write, 0 = read
d_addr  in  ADDR_WIDTH  data address
d_wdata  in  DATA_WIDTH  store data
d_wstrb  in  DATA_WIDTH/8  store byte strobes
d_rdata  out  DATA_WIDTH  load data, valid when d_done
d_done  out  1  one-cycle completion pulse for port D
d_err  out  1  asserted with d_done if rresp/bresp != OKAY
m_awaddr, m_awvalid, m_awready  out/out/in  ADDR_WIDTH/1/1  write address channel
m_wdata, m_wstrb, m_wvalid, m_wready  out/out/out/in  DATA_WIDTH/DATA_WIDTH/8/1/1  write data channel
m_bresp, m_bvalid, m_bready  in/in/out  2/1/1  write response channel
m_araddr, m_arvalid, m_arready  out/out/in  ADDR_WIDTH/1/1  read address channel
m_rdata, m_rresp, m_rvalid, m_rready  in/in/in/out  DATA_WIDTH/2/1/1  read data channel

Behaviour:
- Reset (clk edge with rst=1):
  - State = IDLE; last_grant = I, so D wins first contention.
  - All m_*valid, m_bready, m_rready, i_done, d_done, i_err, d_err = 0.
  - i_rdata = d_rdata = 0; all address/data outputs = 0.
- Reset mid-transaction aborts silently: no done pulse, valids drop next edge.
- States: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE.
- IDLE:
  - Sample requests. Only one requesting: grant it.
  - Both requesting: grant the port not in last_grant; update last_grant on every grant.
  - Latch address/data/strobe/we (port I forces we=0).
  - Read goes to RD_ADDR; write goes to WR_REQ.
  - The m_*valid outputs are registered and rise on the edge leaving IDLE.
- RD_ADDR: m_arvalid=1 until m_arready; on handshake go to RD_DATA.
- RD_DATA:
  - m_rready=1.
  - On m_rvalid: latch m_rdata into the granted port's rdata and err = (m_rresp != 2'b00); go to DONE.
- WR_REQ:
  - m_awvalid and m_wvalid asserted together.
  - Each deasserts independently on its own handshake; AW and W may complete in either order or the same cycle.
  - When both are complete, go to WR_RESP.
- WR_RESP:
  - m_bready=1.
  - On m_bvalid: d_err = (m_bresp != 2'b00); go to DONE.
- DONE:
  - Granted port's done=1 for exactly this cycle; the other port's done=0.
  - Next state IDLE.
  - Requester drops or changes req on the cycle after done.
- Throughput: minimum read = 4 cycles from IDLE (IDLE, RD_ADDR with arready=1, RD_DATA with rvalid=1, DONE).
- Valid/ready protocol:
  - No valid deasserts before its handshake.
  - Address/data outputs are stable while valid=1.
  - No combinational path from m_*ready to m_*valid.
- The unselected port's rdata holds its previous value.
- err outputs are 0 whenever the corresponding done is 0.
- req dropping mid-transaction is illegal; the transaction completes regardless.
- A req still high in the IDLE cycle after DONE is treated as a new request.

Test Plan:
- Single fetch:
  - Stimulus: i_req=1, i_addr=0x0000_0100; slave arready on first cycle, rvalid next cycle with rdata=0x0010_0093, rresp=0.
  - Required: m_araddr=0x100; i_done pulses 1 cycle at cycle 4 with i_rdata=0x0010_0093, i_err=0.
- Store with W before AW:
  - Stimulus: d_we=1, d_addr=0x2000_0004, d_wdata=0xDEAD_BEEF, d_wstrb=4'b0011; wready held 1, awready delayed 3 cycles, bresp=0.
  - Required: m_wvalid drops after 1 cycle; m_awvalid stays high 3 cycles with stable awaddr; d_done=1 once, d_err=0.
- Contention:
  - Stimulus: i_req and d_req high together from reset.
  - Required: D granted first, then I; i_req and d_req held high continuously then alternate I, D, I.
- Error response:
  - Stimulus: data read with rresp=2'b10.
  - Required: d_done=1 with d_err=1; following OKAY read gives d_err=0.
- Backpressure:
  - Stimulus: arready low 5 cycles.
  - Required: m_arvalid and m_araddr stable for all 5 cycles; no done until rvalid.
- Reset mid-transaction:
  - Stimulus: rst asserted during WR_RESP.
  - Required: all valids/readies 0 next edge; no d_done; next request starts cleanly from IDLE.

Source files
------------

// File: rtl/axi_lite_mem_arbiter.sv
// axi_lite_mem_arbiter: shares one AXI4-Lite master between the fetch (I) and load/store (D) ports,
// one transaction at a time, round-robin on contention.
module axi_lite_mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_req,
  input  logic [ADDR_WIDTH-1:0]   i_addr,
  output logic [DATA_WIDTH-1:0]   i_rdata,
  output logic                    i_done,
  output logic                    i_err,
  input  logic                    d_req,
  input  logic                    d_we,
  input  logic [ADDR_WIDTH-1:0]   d_addr,
  input  logic [DATA_WIDTH-1:0]   d_wdata,
  input  logic [DATA_WIDTH/8-1:0] d_wstrb,
  output logic [DATA_WIDTH-1:0]   d_rdata,
  output logic                    d_done,
  output logic                    d_err,
  output logic [ADDR_WIDTH-1:0]   m_awaddr,
  output logic                    m_awvalid,
  input  logic                    m_awready,
  output logic [DATA_WIDTH-1:0]   m_wdata,
  output logic [DATA_WIDTH/8-1:0] m_wstrb,
  output logic                    m_wvalid,
  input  logic                    m_wready,
  input  logic [1:0]              m_bresp,
  input  logic                    m_bvalid,
  output logic                    m_bready,
  output logic [ADDR_WIDTH-1:0]   m_araddr,
  output logic                    m_arvalid,
  input  logic                    m_arready,
  input  logic [DATA_WIDTH-1:0]   m_rdata,
  input  logic [1:0]              m_rresp,
  input  logic                    m_rvalid,
  output logic                    m_rready
);
  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE} state_t;
  state_t state, state_n;
  logic gnt_d, last_d, aw_pend, w_pend, err, any_req, pick_d, wr;
  logic [ADDR_WIDTH-1:0] addr_r;
  assign any_req = i_req | d_req;
  assign pick_d = d_req & (~i_req | ~last_d);
  assign wr = pick_d & d_we;
  assign m_araddr = addr_r;
  assign m_awaddr = addr_r;
  assign m_arvalid = state == RD_ADDR;
  assign m_rready = state == RD_DATA;
  assign m_bready = state == WR_RESP;
  assign m_awvalid = aw_pend;
  assign m_wvalid = w_pend;
  assign i_done = (state == DONE) & ~gnt_d;
  assign d_done = (state == DONE) & gnt_d;
  assign i_err = i_done & err;
  assign d_err = d_done & err;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = any_req ? (wr ? WR_REQ : RD_ADDR) : IDLE;
      RD_ADDR: state_n = m_arready ? RD_DATA : RD_ADDR;
      RD_DATA: state_n = m_rvalid ? DONE : RD_DATA;
      WR_REQ:  state_n = ((~aw_pend | m_awready) & (~w_pend | m_wready)) ? WR_RESP : WR_REQ;
      WR_RESP: state_n = m_bvalid ? DONE : WR_RESP;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_d <= 1'b0;
      last_d <= 1'b0;
      aw_pend <= 1'b0;
      w_pend <= 1'b0;
      err <= 1'b0;
      addr_r <= '0;
      m_wdata <= '0;
      m_wstrb <= '0;
      i_rdata <= '0;
      d_rdata <= '0;
    end else begin
      if (state == IDLE && any_req) begin
        gnt_d <= pick_d;
        last_d <= pick_d;
        addr_r <= pick_d ? d_addr : i_addr;
        aw_pend <= wr;
        w_pend <= wr;
        if (wr) begin
          m_wdata <= d_wdata;
          m_wstrb <= d_wstrb;
        end
      end
      // AW and W retire independently; WR_REQ exits once both flags are clear
      if (aw_pend && m_awready) aw_pend <= 1'b0;
      if (w_pend && m_wready) w_pend <= 1'b0;
      if (state == RD_DATA && m_rvalid) begin
        err <= m_rresp != 2'b00;
        if (gnt_d) d_rdata <= m_rdata;
        else i_rdata <= m_rdata;
      end
      if (state == WR_RESP && m_bvalid) err <= m_bresp != 2'b00;
    end
  end
endmodule

// File: tb/tb_axi_lite_mem_arbiter.sv
// tb_axi_lite_mem_arbiter: directed and randomized checks against a memory/round-robin reference model.
module tb_axi_lite_mem_arbiter;
  logic clk = 1'b0, rst;
  logic i_req, i_done, i_err, d_req, d_we, d_done, d_err;
  logic [31:0] i_addr, i_rdata, d_addr, d_wdata, d_rdata;
  logic [3:0] d_wstrb, m_wstrb;
  logic [31:0] m_awaddr, m_wdata, m_araddr, m_rdata;
  logic m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic m_arvalid, m_arready, m_rvalid, m_rready;
  logic [1:0] m_bresp, m_rresp;
  int checks = 0, errors = 0;
  int ar_dly = 0, aw_dly = 0, w_dly = 0, r_dly = 0, b_dly = 0;
  logic [1:0] rresp_cfg = 2'b00, bresp_cfg = 2'b00;
  logic [31:0] slv_mem [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] exp_i_rd, exp_d_rd;
  bit last_d;

  always #5 clk = ~clk;

  axi_lite_mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done), .i_err(i_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_rdata(d_rdata), .d_done(d_done), .d_err(d_err),
    .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready)
  );

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] ws);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (ws[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  function automatic logic [31:0] slv_rd(input logic [31:0] a);
    return slv_mem.exists(a) ? slv_mem[a] : init_val(a);
  endfunction

  // AXI4-Lite slave: decides readies/valids each falling edge; handshakes land on the next rising edge
  initial begin
    bit ar_hs, aw_hs, w_hs, r_hs, b_hs, rd_act, b_act, got_aw, got_w;
    int ar_c, aw_c, w_c, r_c, b_c;
    logic [31:0] ra, wa, wd;
    logic [3:0] ws;
    {ar_hs, aw_hs, w_hs, r_hs, b_hs, rd_act, b_act, got_aw, got_w} = '0;
    {ar_c, aw_c, w_c, r_c, b_c} = '0;
    {ra, wa, wd, ws} = '0;
    {m_awready, m_wready, m_arready, m_rvalid, m_bvalid} = '0;
    m_rdata = '0; m_rresp = '0; m_bresp = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        {ar_hs, aw_hs, w_hs, r_hs, b_hs, rd_act, b_act, got_aw, got_w} = '0;
        {ar_c, aw_c, w_c, r_c, b_c} = '0;
        {m_awready, m_wready, m_arready, m_rvalid, m_bvalid} = '0;
        m_rdata = '0; m_rresp = '0; m_bresp = '0;
      end else begin
        if (ar_hs) begin rd_act = 1'b1; r_c = 0; end
        if (r_hs) rd_act = 1'b0;
        if (aw_hs) got_aw = 1'b1;
        if (w_hs) got_w = 1'b1;
        if (b_hs) b_act = 1'b0;
        if (got_aw && got_w) begin
          slv_mem[wa] = merge(slv_rd(wa), wd, ws);
          got_aw = 1'b0; got_w = 1'b0; b_act = 1'b1; b_c = 0;
        end
        m_arready = m_arvalid && ar_c >= ar_dly;
        ar_hs = m_arvalid && m_arready;
        ar_c = (m_arvalid && !m_arready) ? ar_c + 1 : 0;
        if (ar_hs) ra = m_araddr;
        m_awready = m_awvalid && aw_c >= aw_dly;
        aw_hs = m_awvalid && m_awready;
        aw_c = (m_awvalid && !m_awready) ? aw_c + 1 : 0;
        if (aw_hs) wa = m_awaddr;
        m_wready = m_wvalid && w_c >= w_dly;
        w_hs = m_wvalid && m_wready;
        w_c = (m_wvalid && !m_wready) ? w_c + 1 : 0;
        if (w_hs) begin wd = m_wdata; ws = m_wstrb; end
        m_rvalid = rd_act && r_c >= r_dly;
        m_rdata = m_rvalid ? slv_rd(ra) : '0;
        m_rresp = m_rvalid ? rresp_cfg : 2'b00;
        r_hs = m_rvalid && m_rready;
        if (rd_act && !m_rvalid) r_c++;
        m_bvalid = b_act && b_c >= b_dly;
        m_bresp = m_bvalid ? bresp_cfg : 2'b00;
        b_hs = m_bvalid && m_bready;
        if (b_act && !m_bvalid) b_c++;
      end
    end
  end

  task automatic apply_reset();
    rst = 1'b1; i_req = 1'b0; d_req = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_i_rd = '0; exp_d_rd = '0; last_d = 1'b0;
  endtask

  task automatic run_one(input bit pd, input bit we, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] ws, output bit got_d, output logic [31:0] rd,
                         output logic er, output int lat, output bit extra);
    if (pd) begin d_we = we; d_addr = a; d_wdata = wd; d_wstrb = ws; d_req = 1'b1; end
    else begin i_addr = a; i_req = 1'b1; end
    lat = -1; got_d = 1'b0; rd = '0; er = 1'b0;
    for (int c = 1; c <= 200 && lat < 0; c++) begin
      @(negedge clk);
      if (i_done || d_done) begin
        lat = c; got_d = d_done;
        rd = d_done ? d_rdata : i_rdata;
        er = d_done ? d_err : i_err;
        i_req = 1'b0; d_req = 1'b0;
      end
    end
    i_req = 1'b0; d_req = 1'b0;
    @(negedge clk);
    extra = i_done | d_done;
  endtask

  task automatic test_reset();
    rst = 1'b1; i_req = 1'b0; d_req = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({m_arvalid, m_awvalid, m_wvalid, m_bready, m_rready, i_done, d_done, i_err, d_err} !== 9'b0) begin
      errors++; $display("FAIL reset_ctrl got %b exp 0", {m_arvalid, m_awvalid, m_wvalid, m_bready, m_rready, i_done, d_done, i_err, d_err});
    end
    checks++;
    if ({m_araddr, m_awaddr, m_wdata, m_wstrb, i_rdata, d_rdata} !== '0) begin
      errors++; $display("FAIL reset_data araddr %h awaddr %h wdata %h wstrb %h irdata %h drdata %h exp all 0",
                         m_araddr, m_awaddr, m_wdata, m_wstrb, i_rdata, d_rdata);
    end
    rst = 1'b0;
    exp_i_rd = '0; exp_d_rd = '0; last_d = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_fetch();
    ar_dly = 0; r_dly = 0; rresp_cfg = 2'b00;
    slv_mem[32'h100] = 32'h0010_0093;
    ref_mem[32'h100] = 32'h0010_0093;
    i_addr = 32'h100; i_req = 1'b1;
    for (int n = 1; n <= 4; n++) begin
      @(negedge clk);
      if (n == 1) begin
        checks++;
        if (m_arvalid !== 1'b1 || m_araddr !== 32'h100) begin
          errors++; $display("FAIL fetch_ar arvalid %b araddr %h exp 1 00000100", m_arvalid, m_araddr);
        end
      end
      checks++;
      if (i_done !== (n == 3)) begin
        errors++; $display("FAIL fetch_done_timing cycle %0d got %b exp %b", n + 1, i_done, n == 3);
      end
      if (n == 3) begin
        checks++;
        if (i_rdata !== 32'h0010_0093 || i_err !== 1'b0 || d_done !== 1'b0) begin
          errors++; $display("FAIL fetch_data rdata %h err %b d_done %b exp 00100093 0 0", i_rdata, i_err, d_done);
        end
        i_req = 1'b0;
      end
    end
  endtask

  task automatic test_store_w_first();
    int dones;
    bit gd, ex;
    logic [31:0] rd;
    logic er;
    int lat;
    aw_dly = 2; w_dly = 0; b_dly = 0; bresp_cfg = 2'b00;
    d_we = 1'b1; d_addr = 32'h2000_0004; d_wdata = 32'hDEAD_BEEF; d_wstrb = 4'b0011; d_req = 1'b1;
    dones = 0;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      if (n <= 4) begin
        checks++;
        if (m_awvalid !== (n <= 3) || m_wvalid !== (n == 1)) begin
          errors++; $display("FAIL store_valids cycle %0d awvalid %b wvalid %b exp %b %b", n, m_awvalid, m_wvalid, n <= 3, n == 1);
        end
      end
      if (n <= 3) begin
        checks++;
        if (m_awaddr !== 32'h2000_0004 || m_wdata !== 32'hDEAD_BEEF || m_wstrb !== 4'b0011) begin
          errors++; $display("FAIL store_payload awaddr %h wdata %h wstrb %b exp 20000004 deadbeef 0011", m_awaddr, m_wdata, m_wstrb);
        end
      end
      if (d_done) begin
        dones++;
        checks++;
        if (d_err !== 1'b0) begin errors++; $display("FAIL store_err got %b exp 0", d_err); end
        d_req = 1'b0;
      end
    end
    checks++;
    if (dones != 1) begin errors++; $display("FAIL store_done_count got %0d exp 1", dones); end
    ref_mem[32'h2000_0004] = merge(ref_rd(32'h2000_0004), 32'hDEAD_BEEF, 4'b0011);
    ar_dly = 0; r_dly = 0; rresp_cfg = 2'b00;
    run_one(1'b1, 1'b0, 32'h2000_0004, '0, '0, gd, rd, er, lat, ex);
    checks++;
    if (lat < 0 || !gd || rd !== ref_rd(32'h2000_0004) || ex) begin
      errors++; $display("FAIL store_readback lat %0d port_d %b data %h extra %b exp data %h", lat, gd, rd, ex, ref_rd(32'h2000_0004));
    end
  endtask

  task automatic test_error_response();
    bit gd, ex;
    logic [31:0] rd;
    logic er;
    int lat;
    ar_dly = 0; r_dly = 1; rresp_cfg = 2'b10;
    run_one(1'b1, 1'b0, 32'h2000_000C, '0, '0, gd, rd, er, lat, ex);
    checks++;
    if (lat < 0 || !gd || er !== 1'b1 || rd !== ref_rd(32'h2000_000C) || ex) begin
      errors++; $display("FAIL err_slverr lat %0d port_d %b err %b data %h exp err 1 data %h", lat, gd, er, rd, ref_rd(32'h2000_000C));
    end
    checks++;
    if (d_err !== 1'b0) begin errors++; $display("FAIL err_idle d_err %b exp 0", d_err); end
    rresp_cfg = 2'b00;
    run_one(1'b1, 1'b0, 32'h2000_0010, '0, '0, gd, rd, er, lat, ex);
    checks++;
    if (lat < 0 || !gd || er !== 1'b0 || rd !== ref_rd(32'h2000_0010)) begin
      errors++; $display("FAIL err_okay lat %0d port_d %b err %b data %h exp err 0 data %h", lat, gd, er, rd, ref_rd(32'h2000_0010));
    end
    r_dly = 0;
  endtask

  task automatic test_backpressure();
    logic [31:0] a;
    a = 32'h2000_0008;
    ar_dly = 5; r_dly = 0; rresp_cfg = 2'b00;
    i_addr = a; i_req = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      if (n <= 6) begin
        checks++;
        if (m_arvalid !== 1'b1 || m_araddr !== a) begin
          errors++; $display("FAIL bp_ar cycle %0d arvalid %b araddr %h exp 1 %h", n, m_arvalid, m_araddr, a);
        end
      end
      checks++;
      if (i_done !== (n == 8)) begin
        errors++; $display("FAIL bp_done cycle %0d got %b exp %b", n, i_done, n == 8);
      end
      if (n == 8) begin
        checks++;
        if (i_rdata !== ref_rd(a) || i_err !== 1'b0) begin
          errors++; $display("FAIL bp_data rdata %h err %b exp %h 0", i_rdata, i_err, ref_rd(a));
        end
        i_req = 1'b0;
      end
    end
    ar_dly = 0;
    @(negedge clk);
  endtask

  task automatic test_contention();
    bit exp_p[$];
    bit l;
    int got;
    logic [31:0] ai, ad;
    apply_reset();
    ai = 32'h2000_0010; ad = 32'h2000_0014; l = last_d;
    for (int k = 0; k < 4; k++) begin l = !l; exp_p.push_back(l); end
    last_d = l;
    ar_dly = 1; r_dly = 0; rresp_cfg = 2'b00;
    i_addr = ai; d_addr = ad; d_we = 1'b0; i_req = 1'b1; d_req = 1'b1; got = 0;
    for (int c = 0; c < 100 && got < 4; c++) begin
      @(negedge clk);
      if (i_done || d_done) begin
        checks++;
        if (d_done !== exp_p[got] || i_done !== !exp_p[got]) begin
          errors++; $display("FAIL contention_order grant %0d got d_done %b i_done %b exp d_done %b", got, d_done, i_done, exp_p[got]);
        end
        if (exp_p[got]) exp_d_rd = ref_rd(ad);
        else exp_i_rd = ref_rd(ai);
        checks++;
        if (i_rdata !== exp_i_rd || d_rdata !== exp_d_rd) begin
          errors++; $display("FAIL contention_data i %h d %h exp i %h d %h", i_rdata, d_rdata, exp_i_rd, exp_d_rd);
        end
        got++;
        if (got == 4) begin i_req = 1'b0; d_req = 1'b0; end
      end
    end
    checks++;
    if (got != 4) begin errors++; $display("FAIL contention_timeout served %0d exp 4", got); end
    i_req = 1'b0; d_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bit gd, ex, seen;
    logic [31:0] rd, a;
    logic er;
    int lat;
    a = 32'h2000_0018;
    aw_dly = 0; w_dly = 0; b_dly = 10; bresp_cfg = 2'b00;
    d_we = 1'b1; d_addr = a; d_wdata = 32'hCAFE_F00D; d_wstrb = 4'b1111; d_req = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 50 && !seen; c++) begin @(negedge clk); seen = m_bready; end
    checks++;
    if (!seen) begin errors++; $display("FAIL rstmid_wresp bready never seen exp 1"); end
    @(negedge clk);
    rst = 1'b1; d_req = 1'b0;
    @(negedge clk);
    checks++;
    if ({m_arvalid, m_awvalid, m_wvalid, m_bready, m_rready, d_done, i_done} !== 7'b0) begin
      errors++; $display("FAIL rstmid_ctrl got %b exp 0", {m_arvalid, m_awvalid, m_wvalid, m_bready, m_rready, d_done, i_done});
    end
    checks++;
    if (i_rdata !== '0 || d_rdata !== '0) begin
      errors++; $display("FAIL rstmid_rdata i %h d %h exp 0 0", i_rdata, d_rdata);
    end
    rst = 1'b0;
    exp_i_rd = '0; exp_d_rd = '0; last_d = 1'b0;
    ref_mem[a] = merge(ref_rd(a), 32'hCAFE_F00D, 4'b1111);
    b_dly = 0;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      checks++;
      if (d_done || i_done || m_arvalid || m_awvalid) begin
        errors++; $display("FAIL rstmid_quiet d_done %b i_done %b arvalid %b awvalid %b exp 0", d_done, i_done, m_arvalid, m_awvalid);
      end
    end
    ar_dly = 0; r_dly = 0; rresp_cfg = 2'b00;
    run_one(1'b1, 1'b0, a, '0, '0, gd, rd, er, lat, ex);
    checks++;
    if (lat != 3 || !gd || rd !== ref_rd(a) || er !== 1'b0 || ex) begin
      errors++; $display("FAIL rstmid_restart lat %0d port_d %b data %h err %b exp lat 3 data %h", lat, gd, rd, er, ref_rd(a));
    end
  endtask

  task automatic test_random(input int iters);
    bit exp_p[$];
    bit p, we, f;
    int mode, served;
    logic [31:0] ia, da, wd;
    logic [3:0] ws;
    logic e_er;
    apply_reset();
    for (int it = 0; it < iters; it++) begin
      mode = int'($urandom_range(0, 2));
      we = 1'($urandom_range(0, 1));
      ia = 32'h2000_0000 | (32'($urandom_range(0, 7)) << 2);
      da = 32'h2000_0000 | (32'($urandom_range(0, 7)) << 2);
      wd = $urandom;
      ws = 4'($urandom_range(0, 15));
      ar_dly = int'($urandom_range(0, 3)); aw_dly = int'($urandom_range(0, 3)); w_dly = int'($urandom_range(0, 3));
      r_dly = int'($urandom_range(0, 3)); b_dly = int'($urandom_range(0, 3));
      rresp_cfg = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      bresp_cfg = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      exp_p.delete();
      if (mode == 2) begin
        f = !last_d;
        exp_p.push_back(f); exp_p.push_back(!f);
      end else exp_p.push_back(mode == 1);
      last_d = exp_p[exp_p.size() - 1];
      i_addr = ia; i_req = (mode != 1);
      d_we = we; d_addr = da; d_wdata = wd; d_wstrb = ws; d_req = (mode != 0);
      served = 0;
      for (int c = 0; c < 300 && served < exp_p.size(); c++) begin
        @(negedge clk);
        checks++;
        if ((i_err && !i_done) || (d_err && !d_done) || (i_done && d_done)) begin
          errors++; $display("FAIL rand_stray it %0d i_done %b i_err %b d_done %b d_err %b", it, i_done, i_err, d_done, d_err);
        end
        if (i_done || d_done) begin
          p = exp_p[served];
          if (p && we) begin
            ref_mem[da] = merge(ref_rd(da), wd, ws);
            e_er = bresp_cfg != 2'b00;
          end else begin
            if (p) exp_d_rd = ref_rd(da);
            else exp_i_rd = ref_rd(ia);
            e_er = rresp_cfg != 2'b00;
          end
          checks++;
          if (d_done !== p) begin errors++; $display("FAIL rand_grant it %0d d_done %b exp %b", it, d_done, p); end
          checks++;
          if (i_rdata !== exp_i_rd || d_rdata !== exp_d_rd) begin
            errors++; $display("FAIL rand_rdata it %0d i %h d %h exp i %h d %h", it, i_rdata, d_rdata, exp_i_rd, exp_d_rd);
          end
          checks++;
          if ((p ? d_err : i_err) !== e_er) begin
            errors++; $display("FAIL rand_err it %0d got %b exp %b", it, p ? d_err : i_err, e_er);
          end
          if (p) d_req = 1'b0;
          else i_req = 1'b0;
          served++;
        end
      end
      checks++;
      if (served != exp_p.size()) begin
        errors++; $display("FAIL rand_timeout it %0d served %0d exp %0d", it, served, exp_p.size());
      end
      i_req = 1'b0; d_req = 1'b0;
      @(negedge clk);
      checks++;
      if (i_done || d_done) begin errors++; $display("FAIL rand_pulse it %0d i_done %b d_done %b exp 0 0", it, i_done, d_done); end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_wstrb = '0;
    test_reset();
    test_single_fetch();
    test_store_w_first();
    test_error_response();
    test_backpressure();
    test_contention();
    test_reset_mid();
    test_random(60);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
